// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants, line-clear FSM state type and the
// points-per-lines mapping used by the score accumulator.
package tetris_pkg;

    localparam int ROWS    = 20;
    localparam int COLS    = 10;
    localparam int SCORE_W = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Points awarded for clearing n rows in a single operation.
    function automatic logic [3:0] linePoints(input logic [4:0] n);
        logic [3:0] pts;
        case (n)
            5'd0:    pts = 4'd0;
            5'd1:    pts = 4'd1;
            5'd2:    pts = 4'd3;
            5'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/line_clear_score.sv
// Saturating score accumulator for the line-clear engine. Adds the points for
// the number of rows cleared whenever add_en pulses and sticks at all-ones
// instead of wrapping. Only instantiated when LINE_CLEAR_SCORE_EN is defined.
module line_clear_score #(
    parameter int SCORE_W = tetris_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               add_en,
    input  logic [4:0]         n,
    output logic [SCORE_W-1:0] score
);
    import tetris_pkg::*;

    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W:0]   w_sum;

    // One extra bit on the sum exposes the overflow used for saturation.
    assign w_sum = {1'b0, r_score} + {{(SCORE_W-3){1'b0}}, linePoints(n)};

    // Accumulate points on each completed operation, clamping at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else if (add_en) begin
            r_score <= w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
        end
    end

    assign score = r_score;

endmodule

// File: rtl/line_clear.sv
// Post-lock line-clear engine. Captures the board on start, scans rows from
// the bottom up, drops full rows while compacting the rest downward in place,
// zero-fills the vacated top rows and reports the number of rows cleared.
// Define LINE_CLEAR_SCORE_EN to build in the saturating score accumulator;
// without it the score output is tied to zero.
module line_clear #(
    parameter int ROWS    = tetris_pkg::ROWS,
    parameter int COLS    = tetris_pkg::COLS,
    parameter int SCORE_W = tetris_pkg::SCORE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [4:0]           lines_cleared,
    output logic [SCORE_W-1:0]   score
);
    import tetris_pkg::*;

    localparam int PW = $clog2(ROWS);

    state_t               r_state;
    logic [ROWS*COLS-1:0] r_work;
    logic [ROWS*COLS-1:0] r_boardOut;
    logic [PW-1:0]        r_rd;
    logic [PW-1:0]        r_wr;
    logic [4:0]           r_n;
    logic [4:0]           r_lines;
    logic                 r_busy;
    logic                 r_done;

    logic [COLS-1:0]      w_rowRd;
    logic                 w_rowFull;
    logic [ROWS*COLS-1:0] w_workNext;
    logic [4:0]           w_nNext;
    logic [SCORE_W-1:0]   w_score;

    // Row under the read pointer and its full-row test; the work register
    // update for this cycle is built here so DONE can publish it directly.
    always_comb begin
        w_rowRd    = r_work[r_rd*COLS +: COLS];
        w_rowFull  = &w_rowRd;
        w_workNext = r_work;
        w_nNext    = r_n;
        case (r_state)
            SCAN: begin
                if (w_rowFull) begin
                    w_nNext = r_n + 5'd1;
                end else begin
                    w_workNext[r_wr*COLS +: COLS] = w_rowRd;
                end
            end
            FILL: begin
                w_workNext[r_wr*COLS +: COLS] = '0;
            end
            default: begin
            end
        endcase
    end

    // Control FSM: the write pointer never passes the read pointer, so the
    // compaction can overwrite rows in place without losing unread data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_boardOut <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_n        <= '0;
            r_lines    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work  <= board_in;
                        r_rd    <= PW'(ROWS-1);
                        r_wr    <= PW'(ROWS-1);
                        r_n     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_work <= w_workNext;
                    r_n    <= w_nNext;
                    r_rd   <= r_rd - 1'b1;
                    if (!w_rowFull) begin
                        r_wr <= r_wr - 1'b1;
                    end
                    if (r_rd == '0) begin
                        if (w_nNext != 5'd0) begin
                            r_state <= FILL;
                        end else begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_boardOut <= w_workNext;
                            r_lines    <= w_nNext;
                        end
                    end
                end
                FILL: begin
                    r_work <= w_workNext;
                    r_wr   <= r_wr - 1'b1;
                    if (r_wr == '0) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_boardOut <= w_workNext;
                        r_lines    <= r_n;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    line_clear_score #(
        .SCORE_W (SCORE_W)
    ) u_score (
        .clk    (clk),
        .rst_n  (rst_n),
        .add_en (r_done),
        .n      (r_lines),
        .score  (w_score)
    );
`else
    assign w_score = '0;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign board_out     = r_boardOut;
    assign lines_cleared = r_lines;
    assign score         = w_score;

endmodule

// File: doc/line_clear.md
# line_clear

Post-lock line-clear engine for the Tetris playfield. It sits between the game controller's lock event and the board register. On a start pulse it captures the 200-bit board, removes every full row, compacts the remaining rows downward, and reports the number of rows cleared. It also keeps the running score that drives the seven-segment score display.

## Interface
Parameters:
- ROWS, 20, playfield rows; row 0 is the top, row ROWS-1 is the bottom.
- COLS, 10, playfield columns; board bit index = row*COLS+col.
- SCORE_W, 15, score width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse after a piece locks; sampled only in IDLE.
- board_in  in  ROWS*COLS  board snapshot, captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; board_out and lines_cleared are valid in this cycle.
- board_out  out  ROWS*COLS  compacted board; holds its value until the next done.
- lines_cleared  out  5  full rows removed by the last operation; holds until the next done.
- score  out  SCORE_W  accumulated score.

## Operation
- FSM states: IDLE, SCAN, FILL, DONE.
- IDLE, start=1:
  - Load board_in into the internal work register.
  - Set read pointer r = ROWS-1 and write pointer w = ROWS-1; set count n = 0.
  - Next state SCAN.
- SCAN, one row per cycle:
  - If row r is all ones: n++, r--.
  - Otherwise: copy row r to row w, then w--, r--.
  - Because w >= r always holds, the compaction is safe in place.
  - After row 0 is processed, go to FILL if n>0, else DONE.
- FILL, one row per cycle: zero row w, w--. Leave when w has wrapped below 0, after exactly n cycles. Next state DONE.
- DONE:
  - board_out <= work register; lines_cleared <= n; done=1.
  - Score update (when enabled).
  - Next state IDLE.
- Points by n: 0→0, 1→1, 2→3, 3→5, ≥4→8.
- Score adds points and saturates at 2^SCORE_W-1; it never wraps.
- start outside IDLE is ignored; it is not queued.
- An all-full board (n=ROWS) yields an all-zero board_out and lines_cleared=20.
- An empty board yields board_out=0 and lines_cleared=0, and still produces done.

## Timing
- Reset values: state=IDLE, busy=0, done=0, board_out=0, lines_cleared=0, score=0, work register=0.
- start accepted at edge k:
  - SCAN occupies cycles k+1..k+ROWS.
  - FILL occupies the next n cycles.
  - done is high in cycle k+ROWS+n+1.
- Latency therefore ranges from 21 cycles (n=0) to 41 cycles (n=20). A normal game clears at most 4 rows, so 25 cycles.
- busy falls on the edge that ends DONE. A start in the first IDLE cycle after that is accepted, giving back-to-back operations.
- Reset asserted mid-operation aborts at once:
  - Return to IDLE.
  - No done pulse.
  - board_out, lines_cleared and score go to 0.
- Reset has priority over start in the same cycle.

## Configuration
- LINE_CLEAR_SCORE_EN defined: the score accumulator and points mapping are compiled in, and score behaves as described above.
- LINE_CLEAR_SCORE_EN undefined: the accumulator is removed and score is tied to 0. All other behaviour and timing are identical.

## Structure
- Shared package tetris_pkg holds:
  - ROWS, COLS, SCORE_W constants.
  - The FSM state type (IDLE/SCAN/FILL/DONE).
  - The points-per-lines mapping function.
- Sub-module line_clear_score holds the saturating score accumulator. Inputs: clk, rst_n, add_en, n. Output: score. It is instantiated only under LINE_CLEAR_SCORE_EN.
- Full-row detection is a COLS-wide AND on the row selected by r, kept inline.

## Test plan
- Reset, then start with an empty board → done at cycle 21, board_out=0, lines_cleared=0, score=0.
- Row 19 full, bit 18*10+3 set → done at cycle 22; board_out has only bit 19*10+3 set; lines_cleared=1; score=1.
- Rows 19,17,16,15 full, row 18 = 10'b0000000011 → done at cycle 25; row 19 = 10'b0000000011, all other rows 0; lines_cleared=4; score=8.
- Preload score to 32765, then clear 2 rows → score=32767 (saturated). A further 1-row clear leaves score=32767.
- Pulse start again at cycle 5 of an operation → ignored; exactly one done is produced and the result matches the first snapshot.
- Assert rst_n=0 during FILL → busy=0 immediately, no done, outputs 0. The next start then completes normally.
